// File: rtl/tap_period_meter_pkg.sv
// Shared types and constants for the tap period meter and its synchronizer.
// Holds the FSM state encoding and the legal synchronizer depth range.
package tap_meter_pkg;

   localparam int ST_W            = 2;
   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2
   } state_t;

   function automatic logic sync_stages_legal(input int stages);
      return (stages >= SYNC_STAGES_MIN) && (stages <= SYNC_STAGES_MAX);
   endfunction

endpackage

// File: rtl/tap_period_meter_sync_rise_detect.sv
// Multi-flop synchronizer for an asynchronous tap plus rising-edge detector.
// rise is the unregistered detect (from flops only); rise_pulse is its registered copy.
module sync_rise_detect
   import tap_meter_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;
   logic                   prev_d;
   logic                   pulse_q;
   logic                   pulse_d;

   assign rise       = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign rise_pulse = pulse_q;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d  = sync_q[SYNC_STAGES-1];
      pulse_d = rise;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   generate
      if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_stages
         $error("sync_rise_detect: SYNC_STAGES out of legal range");
      end
   endgenerate

endmodule

// File: rtl/tap_period_meter.sv
// Measures the period of an asynchronous divided-clock tap in CLK cycles,
// with a one-cycle valid strobe per measurement and a sticky stall flag.
module tap_period_meter
   import tap_meter_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             TAP_IN,
   input  logic             EN,
   output logic             EDGE_PULSE,
   output logic [CNT_W-1:0] PERIOD,
   output logic             PERIOD_VLD,
   output logic             TIMEOUT,
   output logic             BUSY
);

   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic [CNT_W-1:0]   period_q;
   logic [CNT_W-1:0]   period_d;
   logic               vld_q;
   logic               vld_d;
   logic               timeout_q;
   logic               timeout_d;
   logic               busy_q;
   logic               busy_d;
   logic               tap_rise;

   sync_rise_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk        (CLK),
      .rst_n      (RST_N),
      .async_in   (TAP_IN),
      .rise       (tap_rise),
      .rise_pulse (EDGE_PULSE)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      vld_d     = 1'b0;
      timeout_d = timeout_q;

      if (!EN) begin
         // Disable overrides everything, including a coincident edge.
         state_d   = ST_IDLE;
         cnt_d     = '0;
         timeout_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d   = '0;
               state_d = ST_ARM;
            end
            ST_ARM: begin
               if (tap_rise) begin
                  cnt_d   = CNT_ONE;
                  state_d = ST_MEAS;
               end
            end
            ST_MEAS: begin
               // An edge on the timeout cycle still yields a measurement.
               if (tap_rise) begin
                  period_d  = cnt_q;
                  vld_d     = 1'b1;
                  timeout_d = 1'b0;
                  cnt_d     = CNT_ONE;
               end else if (cnt_q == TIMEOUT_VAL) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_ARM;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         period_q  <= '0;
         vld_q     <= 1'b0;
         timeout_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         vld_q     <= vld_d;
         timeout_q <= timeout_d;
         busy_q    <= busy_d;
      end
   end

   assign PERIOD     = period_q;
   assign PERIOD_VLD = vld_q;
   assign TIMEOUT    = timeout_q;
   assign BUSY       = busy_q;

   generate
      if (TIMEOUT_CYC < 2) begin : g_timeout_too_small
         $error("tap_period_meter: TIMEOUT_CYC must be at least 2");
      end
      if (longint'(TIMEOUT_CYC) >= (longint'(1) << CNT_W)) begin : g_timeout_too_big
         $error("tap_period_meter: TIMEOUT_CYC must fit in CNT_W bits");
      end
   endgenerate

endmodule

// File: tb/tb_tap_period_meter.sv
// Directed bench for tap_period_meter: timestamp-based reference model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_tap_period_meter;

   localparam int S  = 2;
   localparam int CW = 16;
   localparam int TO = 100;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          tap_in = 1'b0;
   logic          en     = 1'b0;
   logic          edge_pulse;
   logic [CW-1:0] period;
   logic          period_vld;
   logic          timeout;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   // reference model state
   logic [S+1:0]  hist = '0;
   int            cyc = 0;
   bit            active = 0;
   bit            have_ref = 0;
   int            ref_cyc = 0;
   logic          exp_edge = 1'b0;
   logic          exp_vld = 1'b0;
   logic          exp_to = 1'b0;
   logic          exp_busy = 1'b0;
   logic [CW-1:0] exp_period = '0;

   // observation bookkeeping
   int   log_q[$];
   int   edge_cnt = 0;
   int   vld_cnt = 0;
   int   ncyc = 0;
   int   last_edge_obs = 0;
   int   to_rise_obs = 0;
   logic to_prev = 1'b0;

   always #5 clk = ~clk;

   tap_period_meter #(
      .SYNC_STAGES(S),
      .CNT_W      (CW),
      .TIMEOUT_CYC(TO)
   ) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .TAP_IN    (tap_in),
      .EN        (en),
      .EDGE_PULSE(edge_pulse),
      .PERIOD    (period),
      .PERIOD_VLD(period_vld),
      .TIMEOUT   (timeout),
      .BUSY      (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic model_reset();
      hist       = '0;
      active     = 0;
      have_ref   = 0;
      exp_edge   = 1'b0;
      exp_vld    = 1'b0;
      exp_to     = 1'b0;
      exp_busy   = 1'b0;
      exp_period = '0;
   endtask

   // Edges are timestamps; a period is the distance between two of them.
   task automatic model_step();
      logic det;
      hist     = {hist[S:0], tap_in};
      det      = hist[S] & ~hist[S+1];
      exp_edge = det;
      exp_vld  = 1'b0;
      if (!en) begin
         active   = 0;
         have_ref = 0;
         exp_to   = 1'b0;
      end else if (!active) begin
         active   = 1;
         have_ref = 0;
      end else if (!have_ref) begin
         if (det) begin
            have_ref = 1;
            ref_cyc  = cyc;
         end
      end else if (det) begin
         exp_period = CW'(cyc - ref_cyc);
         exp_vld    = 1'b1;
         exp_to     = 1'b0;
         ref_cyc    = cyc;
      end else if (cyc - ref_cyc == TO) begin
         exp_to   = 1'b1;
         have_ref = 0;
      end
      exp_busy = active;
      cyc++;
   endtask

   task automatic model_loop();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   endtask

   task automatic cmp_loop();
      forever begin
         @(negedge clk);
         ncyc++;
         chk("edge_pulse", edge_pulse, exp_edge);
         chk("period_vld", period_vld, exp_vld);
         chk("period",     period,     exp_period);
         chk("timeout",    timeout,    exp_to);
         chk("busy",       busy,       exp_busy);
         if (period_vld === 1'b1) begin
            log_q.push_back(int'(period));
            vld_cnt++;
         end
         if (edge_pulse === 1'b1) begin
            edge_cnt++;
            last_edge_obs = ncyc;
         end
         if (timeout === 1'b1 && to_prev !== 1'b1) to_rise_obs = ncyc;
         to_prev = timeout;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic hold(input logic lvl, input int n);
      tap_in = lvl;
      repeat (n) tick();
   endtask

   task automatic periods(input int hi, input int lo, input int n);
      repeat (n) begin
         hold(1'b1, hi);
         hold(1'b0, lo);
      end
   endtask

   initial begin
      int lat;
      int n16;
      int n40;
      int nodd;
      int vcnt0;

      fork
         model_loop();
         cmp_loop();
      join_none

      #2 rst_n = 1'b0;
      tick();

      // reset held while the tap toggles
      for (int i = 0; i < 8; i++) begin
         tap_in = i[1];
         tick();
      end
      chk("rst_edge",    edge_pulse, 0);
      chk("rst_vld",     period_vld, 0);
      chk("rst_period",  period,     0);
      chk("rst_timeout", timeout,    0);
      chk("rst_busy",    busy,       0);
      tap_in = 1'b0;
      tick();
      rst_n = 1'b1;

      // disabled: edges detected, nothing measured
      edge_cnt = 0;
      vld_cnt  = 0;
      periods(8, 8, 3);
      chk("idle_edges",  edge_cnt, 3);
      chk("idle_vld",    vld_cnt,  0);
      chk("idle_busy",   busy,     0);

      // steady 16-cycle tap, first edge arms only
      en = 1'b1;
      log_q.delete();
      tap_in = 1'b1;
      lat = 0;
      while (edge_pulse !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      chk("edge_latency", lat, S + 1);
      hold(1'b1, 8 - lat);
      hold(1'b0, 8);
      periods(8, 8, 5);
      n16 = 0;
      foreach (log_q[i]) if (log_q[i] == 16) n16++;
      chk("steady_count", log_q.size(), 5);
      chk("steady_all16", n16, 5);
      chk("steady_period", period, 16);

      // 16 -> 40 switch with one transitional period of 8+20
      log_q.delete();
      hold(1'b1, 8);
      hold(1'b0, 20);
      periods(20, 20, 4);
      n40 = 0;
      nodd = 0;
      foreach (log_q[i]) begin
         if (log_q[i] == 40) n40++;
         else if (log_q[i] != 16) nodd++;
      end
      chk("switch_count", log_q.size(), 5);
      chk("switch_first", log_q[0], 16);
      chk("switch_trans", log_q[1], 28);
      chk("switch_nodd",  nodd, 1);
      chk("switch_n40",   n40, 3);
      chk("switch_last",  period, 40);

      // stall beyond the timeout
      hold(1'b0, 120);
      chk("stall_timeout", timeout, 1);
      chk("stall_busy",    busy,    1);
      chk("stall_period",  period,  40);
      chk("stall_latency", to_rise_obs - last_edge_obs, TO);
      vcnt0 = vld_cnt;
      periods(8, 8, 1);
      chk("rearm_no_vld",  vld_cnt - vcnt0, 0);
      chk("rearm_timeout", timeout, 1);
      periods(8, 8, 1);
      chk("recover_vld",     vld_cnt - vcnt0, 1);
      chk("recover_timeout", timeout, 0);
      chk("recover_period",  period,  16);

      // EN dropped exactly when an edge is detected
      periods(12, 12, 1);
      hold(1'b1, 12);
      hold(1'b0, 10);
      chk("pre_drop_period", period, 24);
      tap_in = 1'b1;
      tick();
      tick();
      en = 1'b0;
      tick();
      chk("drop_edge",   edge_pulse, 1);
      chk("drop_vld",    period_vld, 0);
      chk("drop_busy",   busy,       0);
      chk("drop_period", period,     24);
      hold(1'b1, 5);
      hold(1'b0, 8);
      chk("drop_hold", period, 24);

      // asynchronous reset mid-count
      en = 1'b1;
      periods(8, 8, 2);
      hold(1'b1, 8);
      hold(1'b0, 4);
      rst_n = 1'b0;
      #1;
      chk("arst_edge",    edge_pulse, 0);
      chk("arst_vld",     period_vld, 0);
      chk("arst_period",  period,     0);
      chk("arst_timeout", timeout,    0);
      chk("arst_busy",    busy,       0);
      tick();
      tick();
      rst_n = 1'b1;
      log_q.delete();
      hold(1'b0, 4);
      periods(8, 8, 3);
      chk("post_rst_count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         chk("post_rst_p0", log_q[0], 16);
         chk("post_rst_p1", log_q[1], 16);
      end

      repeat (4) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tap_period_meter.md
# tap_period_meter

Measures the period of an asynchronous divided-clock tap (a T-flip-flop ripple-chain output such as Q3) in units of the system clock. Sits directly downstream of the ripple divider chain. Synchronizes the tap, detects rising edges, counts CLK cycles between consecutive edges, and reports each period with a one-cycle valid strobe. Flags a sticky timeout when the tap stalls.

## Interface
- SYNC_STAGES, 2, synchronizer flops on TAP_IN; legal range 2..4
- CNT_W, 16, width of period counter and PERIOD output
- TIMEOUT_CYC, 1000, cycles without an edge before TIMEOUT; must be ≥2 and < 2^CNT_W

- CLK  in  1  system clock, rising-edge active
- RST_N  in  1  asynchronous active-low reset; deassertion synchronous to CLK upstream of this block
- TAP_IN  in  1  divided-clock tap, asynchronous to CLK
- EN  in  1  measurement enable, synchronous to CLK
- EDGE_PULSE  out  1  one-cycle pulse per detected TAP_IN rising edge
- PERIOD  out  CNT_W  last measured period in CLK cycles; holds between updates
- PERIOD_VLD  out  1  one-cycle strobe, PERIOD updated this cycle
- TIMEOUT  out  1  sticky stall flag
- BUSY  out  1  high in ARM or MEAS

## Operation
- Reset: all outputs 0, state IDLE, counter 0, synchronizer chain 0, edge-history flop 0.
- Edge detect: sync chain s[0..SYNC_STAGES-1]; edge = s[last] & ~s_prev; EDGE_PULSE is edge registered, independent of EN.
- FSM states: IDLE, ARM, MEAS.
  - IDLE: cnt=0. EN=1 → ARM.
  - ARM: waits for first edge. Edge → MEAS, cnt←1. No PERIOD_VLD for the first edge.
  - MEAS: no edge → cnt←cnt+1. Edge → PERIOD←cnt, PERIOD_VLD=1, TIMEOUT←0, cnt←1, stay MEAS.
  - MEAS, cnt==TIMEOUT_CYC with no edge this cycle → TIMEOUT←1, cnt←0, → ARM. PERIOD unchanged.
  - EN=0 in any state → IDLE next cycle, cnt←0, TIMEOUT←0. PERIOD holds. No PERIOD_VLD, even if an edge coincides.
- Edge and timeout in the same cycle: edge wins, measurement reported, no TIMEOUT.
- Counter never exceeds TIMEOUT_CYC, so no wrap-around at CNT_W.
- Tap pulses narrower than one CLK period may be missed. This is acceptable; the tap must be high and low ≥2 CLK cycles each.
- RST_N assertion mid-measurement: immediate return to reset values. The first edge after reset only arms.

## Timing
- TAP_IN rising, first sampled high at CLK edge k → EDGE_PULSE high during cycle after edge k+SYNC_STAGES, for exactly one cycle.
- PERIOD_VLD and the PERIOD update coincide with EDGE_PULSE in MEAS.
- PERIOD equals the count of CLK edges between consecutive EDGE_PULSE assertions. Example: tap period 16 CLK → PERIOD=16.
- Minimum reportable PERIOD = 4 (2 high + 2 low).
- EN→BUSY latency: 1 cycle. TIMEOUT asserts 1 cycle after cnt reaches TIMEOUT_CYC.
- All outputs registered; no combinational path from input to output.

## Structure
- Package tap_meter_pkg: state enum (ST_IDLE, ST_ARM, ST_MEAS), state width constant, SYNC_STAGES legal-range constants.
- Sub-module sync_rise_detect: SYNC_STAGES synchronizer plus rising-edge pulse. Reused for other async taps.
- Top: FSM, saturating counter, output registers. Elaboration check TIMEOUT_CYC < 2^CNT_W.

## Test plan
- Reset: RST_N low with TAP_IN toggling → all outputs 0. Release, EN=0 → only EDGE_PULSE toggles; PERIOD_VLD stays 0.
- Steady tap, period 16 CLK, EN=1 → first edge no VLD; each later edge PERIOD_VLD=1 with PERIOD=16. Edge-pulse latency is SYNC_STAGES+1 cycles.
- Period change 16→40 mid-run → exactly one transitional value, then PERIOD=40 on every strobe.
- Stall with TIMEOUT_CYC=100 → TIMEOUT=1 at cycle 101 after the last edge, state ARM. Next two edges: first arms, second gives PERIOD_VLD and clears TIMEOUT.
- EN dropped mid-MEAS, coincident with an edge → no PERIOD_VLD, BUSY=0 next cycle, PERIOD holds its prior value.
- RST_N pulsed low mid-count → outputs 0 immediately (asynchronously). After release, the first measurement requires two edges.
